mem_port_arbiter: RTL

- Sits between the dual-issue memory stage and a single-ported data cache/memory. Each cycle the memory stage presents up to two load/store requests (lane 0 older, lane 1 younger).
- The arbiter serializes them onto one request/response port in program order. It stalls the pipeline until both lanes complete, then returns load data per lane.
- The memory stage muxes the returned load data into its commit results in place of the ALU result.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_fsm.sv | 77 +++++++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the dual-lane memory port arbiter: FSM state encoding,
// datapath widths and the single-port request bundle.
package mem_port_arbiter_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int ARB_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5,
    DRAIN = 3'd6
  } arb_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  wdata;
  } mem_port_req_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Sequencing FSM for mem_port_arbiter: walks lane 0 then lane 1 through a
// request/response pair each, and decodes stall/done/m_valid from state.
module mem_arb_fsm
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lane_act_i,
  input  logic       fwd_hit_i,
  input  logic       flush_i,
  input  logic       m_ready_i,
  input  logic       m_rvalid_i,
  output arb_state_t state_o,
  output logic       stall_o,
  output logic       done_o,
  output logic       m_valid_o,
  output logic       lane_sel_o,
  output logic       capture_o
);

  arb_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake: a request transfers on a cycle with m_valid=1 and m_ready=1;
  // payload is held stable until then. Exactly one m_rvalid follows each
  // transfer, never in the transfer cycle itself.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b1;
    done_o     = 1'b0;
    m_valid_o  = 1'b0;
    lane_sel_o = 1'b0;
    capture_o  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = |lane_act_i;
        if (!flush_i && |lane_act_i) state_d = lane_act_i[0] ? REQ0 : REQ1;
      end
      REQ0, REQ1: begin
        lane_sel_o = (state_q == REQ1);
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          m_valid_o = 1'b1;
          if (m_ready_i) state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
        end
      end
      WAIT0, WAIT1: begin
        lane_sel_o = (state_q == WAIT1);
        // A response landing with the flush needs no drain.
        if (flush_i) begin
          state_d = m_rvalid_i ? IDLE : DRAIN;
        end else if (m_rvalid_i) begin
          capture_o = 1'b1;
          if (state_q == WAIT0 && lane_act_i[1] && !fwd_hit_i) state_d = REQ1;
          else                                                 state_d = DONE;
        end
      end
      DONE: begin
        stall_o = 1'b0;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        if (m_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes two memory-stage lanes onto one request/response port in program
// order. Build with MEM_ARB_FWD_EN to forward a lane-0 store to a same-word
// lane-1 load without a second memory access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = REG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             lane_rd,
  input  logic [1:0]             lane_wr,
  input  logic [1:0][ADDR_W-1:0] lane_addr,
  input  logic [1:0][DATA_W-1:0] lane_wdata,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0][DATA_W-1:0] lane_rdata,
  output logic                   done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_we,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic                   m_rvalid,
  input  logic [DATA_W-1:0]      m_rdata,
  output arb_state_t             dbg_state
);

  logic                   fwd_hit;
  logic                   req_valid;
  logic                   lane_sel;
  logic                   capture;
  mem_port_req_t          req;
  logic [1:0][DATA_W-1:0] lane_rdata_q;

`ifdef MEM_ARB_FWD_EN
  assign fwd_hit = lane_wr[0] && lane_rd[1] &&
                   (lane_addr[1][ADDR_W-1:2] == lane_addr[0][ADDR_W-1:2]);
`else
  assign fwd_hit = 1'b0;
`endif

  mem_arb_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .lane_act_i (lane_rd | lane_wr),
    .fwd_hit_i  (fwd_hit),
    .flush_i    (flush),
    .m_ready_i  (m_ready),
    .m_rvalid_i (m_rvalid),
    .state_o    (dbg_state),
    .stall_o    (stall),
    .done_o     (done),
    .m_valid_o  (req_valid),
    .lane_sel_o (lane_sel),
    .capture_o  (capture)
  );

  // Payload reads zero whenever no request is offered.
  always_comb begin
    req.valid = req_valid;
    req.we    = req_valid & lane_wr[lane_sel];
    req.addr  = req_valid ? lane_addr[lane_sel]  : '0;
    req.wdata = req_valid ? lane_wdata[lane_sel] : '0;
  end

  assign m_valid = req.valid;
  assign m_we    = req.we;
  assign m_addr  = req.addr;
  assign m_wdata = req.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_rdata_q <= '0;
    end else if (capture) begin
      if (lane_rd[lane_sel]) lane_rdata_q[lane_sel] <= m_rdata;
      if (!lane_sel && fwd_hit) lane_rdata_q[1] <= lane_wdata[0];
    end
  end

  assign lane_rdata = lane_rdata_q;

endmodule
